// File: rtl/div_operand_loader_pkg.sv
// Shared types and constants for the divider operand loader.
// The loader gathers four nibbles, lets the divider settle, then offers one result bit.
package div_operand_loader_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  typedef logic [3:0] nibble_t;

  localparam int DEFAULT_SETTLE_CYCLES = 1;

  // Wide enough for the largest legal settle load value (15 - 1)
  localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/div_operand_loader_if.sv
// Handshake and operand bundle between the loader, its upstream nibble source,
// the external divider and the result consumer.
interface div_operand_loader_if #(
  parameter int CNT_W = 8
);
  import div_operand_loader_pkg::*;

  logic             in_valid;
  nibble_t          in_data;
  logic             in_ready;
  logic             flush;
  nibble_t          a;
  nibble_t          b;
  nibble_t          c;
  nibble_t          d;
  logic             div_result;
  logic             out_valid;
  logic             out_result;
  logic             out_ready;
  logic [CNT_W-1:0] true_count;

  // Loader side
  modport slave (
    input  in_valid, in_data, flush, div_result, out_ready,
    output in_ready, a, b, c, d, out_valid, out_result, true_count
  );

  // Environment side: nibble source, divider and result consumer
  modport master (
    output in_valid, in_data, flush, div_result, out_ready,
    input  in_ready, a, b, c, d, out_valid, out_result, true_count
  );

endinterface

// File: rtl/div_operand_loader.sv
// Loads four nibbles into the divider operand registers, waits SETTLE_CYCLES for the
// combinational divider, captures its result and holds it until the consumer takes it.
module div_operand_loader
  import div_operand_loader_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  div_operand_loader_if.slave bus
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_nextState;
  logic [1:0]              r_idx;
  logic [SETTLE_CNT_W-1:0] r_settleCnt;
  nibble_t                 r_a;
  nibble_t                 r_b;
  nibble_t                 r_c;
  nibble_t                 r_d;
  logic                    r_outResult;
  logic [CNT_W-1:0]        r_trueCount;

  logic w_inReady;
  logic w_outValid;
  logic w_accept;
  logic w_deliver;

  assign w_accept  = bus.in_valid && w_inReady;
  assign w_deliver = (r_state == HOLD) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      LOAD:    if (w_accept && (r_idx == 2'd3)) w_nextState = SETTLE;
      SETTLE:  if (r_settleCnt == '0) w_nextState = HOLD;
      HOLD:    if (bus.out_ready) w_nextState = LOAD;
      default: w_nextState = LOAD;
    endcase
  end

  // Handshake outputs are forced low during reset even though the state register still
  // shows the pre-reset state for that cycle.
  always_comb begin
    w_inReady  = 1'b0;
    w_outValid = 1'b0;
    if (!rst) begin
      unique case (r_state)
        LOAD:    w_inReady  = !bus.flush;
        HOLD:    w_outValid = 1'b1;
        default: begin
          w_inReady  = 1'b0;
          w_outValid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= 2'd0;
      r_settleCnt <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_outResult <= 1'b0;
      r_trueCount <= '0;
    end else begin
      if (r_state == LOAD) begin
        if (bus.flush) begin
          r_idx <= 2'd0;
        end else if (w_accept) begin
          unique case (r_idx)
            2'd0: r_a <= bus.in_data;
            2'd1: r_b <= bus.in_data;
            2'd2: r_c <= bus.in_data;
            default: r_d <= bus.in_data;
          endcase
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_settleCnt <= SETTLE_LOAD;
        end
      end

      if (r_state == SETTLE) begin
        if (r_settleCnt == '0) begin
          r_outResult <= bus.div_result;
        end else begin
          r_settleCnt <= r_settleCnt - 1'b1;
        end
      end

      // Saturate rather than wrap so the count never under-reports after overflow
      if (w_deliver && r_outResult && (r_trueCount != '1)) begin
        r_trueCount <= r_trueCount + 1'b1;
      end
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.out_valid  = w_outValid;
  assign bus.out_result = r_outResult;
  assign bus.a          = r_a;
  assign bus.b          = r_b;
  assign bus.c          = r_c;
  assign bus.d          = r_d;
  assign bus.true_count = r_trueCount;

endmodule

// File: tb/tb_div_operand_loader.sv
// Self-checking bench: instance A runs with a one-cycle settle, instance B with three.
// Expected values come from the nibbles the bench sends and simple timing arithmetic.
module tb_div_operand_loader;

  localparam int SETTLE_A = 1;
  localparam int SETTLE_B = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   expCount = 0;
  logic divSelA;
  logic divConstA;
  logic divB;

  always #5 clk = ~clk;

  div_operand_loader_if #(.CNT_W(8)) ifA ();
  div_operand_loader_if #(.CNT_W(8)) ifB ();

  // The stand-in divider for A is the parity of its operands, so a wrong operand shows up
  // as a wrong result as well.
  assign ifA.div_result = divSelA ? ^{ifA.a, ifA.b, ifA.c, ifA.d} : divConstA;
  assign ifB.div_result = divB;

  div_operand_loader #(.SETTLE_CYCLES(SETTLE_A), .CNT_W(8)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA)
  );

  div_operand_loader #(.SETTLE_CYCLES(SETTLE_B), .CNT_W(8)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB)
  );

  function automatic logic par(input logic [15:0] s);
    return ^s;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic sendSetA(input logic [15:0] s);
    for (int i = 0; i < 4; i++) begin
      ifA.in_valid = 1'b1;
      ifA.in_data  = s[15-4*i -: 4];
      tick();
    end
    ifA.in_valid = 1'b0;
  endtask

  // Edges from the 4th accept until out_valid is seen; -1 when it never appears
  task automatic waitValidA(output int n);
    n = 0;
    do begin
      tick();
      n++;
      sample();
    end while (!ifA.out_valid && n < 30);
    if (!ifA.out_valid) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    sample();
    checks++;
    if ({ifA.in_ready, ifA.out_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_handshake: got %b expected 00", {ifA.in_ready, ifA.out_valid});
    end
    checks++;
    if ({ifA.a, ifA.b, ifA.c, ifA.d, ifA.out_result, ifA.true_count} !== 25'd0) begin
      failures++;
      $display("[TB] FAIL reset_values: got %h expected 0",
               {ifA.a, ifA.b, ifA.c, ifA.d, ifA.out_result, ifA.true_count});
    end
    tick();
    rst = 1'b0;
    expCount = 0;
    sample();
    checks++;
    if (ifA.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", ifA.in_ready);
    end
  endtask

  task automatic test_basic();
    int n;
    divSelA = 1'b0;
    divConstA = 1'b1;
    ifA.out_ready = 1'b1;
    sendSetA(16'h3300);
    waitValidA(n);
    checks++;
    if (n !== SETTLE_A) begin
      failures++;
      $display("[TB] FAIL basic_latency: got %0d expected %0d", n, SETTLE_A);
    end
    checks++;
    if ({ifA.a, ifA.b, ifA.c, ifA.d, ifA.out_result, ifA.in_ready} !== {16'h3300, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL basic_result: got ops=%h res=%b rdy=%b expected ops=3300 res=1 rdy=0",
               {ifA.a, ifA.b, ifA.c, ifA.d}, ifA.out_result, ifA.in_ready);
    end
    tick();
    sample();
    expCount = sat(expCount + 1);
    checks++;
    if ({ifA.out_valid, ifA.true_count} !== {1'b0, 8'(expCount)}) begin
      failures++;
      $display("[TB] FAIL basic_delivery: got valid=%b count=%0d expected valid=0 count=%0d",
               ifA.out_valid, ifA.true_count, expCount);
    end
  endtask

  task automatic test_flush();
    int deliveries;
    divSelA = 1'b0;
    divConstA = 1'b0;
    ifA.out_ready = 1'b1;
    ifA.in_valid = 1'b1;
    ifA.in_data = 4'h1;
    tick();
    ifA.in_data = 4'h2;
    tick();
    ifA.in_data = 4'h5;
    ifA.flush = 1'b1;
    sample();
    checks++;
    if (ifA.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_ready: got %b expected 0", ifA.in_ready);
    end
    tick();
    ifA.flush = 1'b0;
    ifA.in_valid = 1'b0;
    sample();
    checks++;
    if ({ifA.a, ifA.b, ifA.c, ifA.d} !== 16'h1200) begin
      failures++;
      $display("[TB] FAIL flush_keep: got %h expected 1200", {ifA.a, ifA.b, ifA.c, ifA.d});
    end
    sendSetA(16'h9999);
    deliveries = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      sample();
      if (ifA.out_valid) deliveries++;
    end
    checks++;
    if (deliveries !== 1 || {ifA.a, ifA.b, ifA.c, ifA.d} !== 16'h9999) begin
      failures++;
      $display("[TB] FAIL flush_reload: got deliveries=%0d ops=%h expected 1 and 9999",
               deliveries, {ifA.a, ifA.b, ifA.c, ifA.d});
    end
    checks++;
    if (ifA.true_count !== 8'(expCount)) begin
      failures++;
      $display("[TB] FAIL flush_count: got %0d expected %0d", ifA.true_count, expCount);
    end
  endtask

  task automatic test_hold();
    int n;
    logic [15:0] s;
    logic expRes;
    divSelA = 1'b1;
    ifA.out_ready = 1'b0;
    s = 16'($urandom);
    expRes = par(s);
    sendSetA(s);
    waitValidA(n);
    checks++;
    if (n !== SETTLE_A) begin
      failures++;
      $display("[TB] FAIL hold_latency: got %0d expected %0d", n, SETTLE_A);
    end
    for (int i = 0; i < 10; i++) begin
      ifA.in_valid = 1'($urandom);
      ifA.in_data  = 4'($urandom);
      ifA.flush    = 1'($urandom);
      tick();
      sample();
      checks++;
      if ({ifA.out_valid, ifA.in_ready, ifA.a, ifA.b, ifA.c, ifA.d, ifA.out_result} !==
          {1'b1, 1'b0, s, expRes}) begin
        failures++;
        $display("[TB] FAIL hold_stable: got v=%b r=%b ops=%h res=%b expected v=1 r=0 ops=%h res=%b",
                 ifA.out_valid, ifA.in_ready, {ifA.a, ifA.b, ifA.c, ifA.d}, ifA.out_result, s, expRes);
      end
    end
    ifA.in_valid = 1'b0;
    ifA.flush = 1'b0;
    ifA.out_ready = 1'b1;
    tick();
    ifA.out_ready = 1'b0;
    expCount = sat(expCount + int'(expRes));
    sample();
    checks++;
    if ({ifA.out_valid, ifA.true_count} !== {1'b0, 8'(expCount)}) begin
      failures++;
      $display("[TB] FAIL hold_release: got valid=%b count=%0d expected valid=0 count=%0d",
               ifA.out_valid, ifA.true_count, expCount);
    end
  endtask

  task automatic test_random();
    int n;
    logic [15:0] s;
    divSelA = 1'b1;
    ifA.out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      s = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
        ifA.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        ifA.in_valid = 1'b1;
        ifA.in_data  = s[15-4*i -: 4];
        tick();
      end
      ifA.in_valid = 1'b0;
      waitValidA(n);
      checks++;
      if (n !== SETTLE_A || {ifA.a, ifA.b, ifA.c, ifA.d, ifA.out_result} !== {s, par(s)}) begin
        failures++;
        $display("[TB] FAIL random_set%0d: got lat=%0d ops=%h res=%b expected lat=%0d ops=%h res=%b",
                 k, n, {ifA.a, ifA.b, ifA.c, ifA.d}, ifA.out_result, SETTLE_A, s, par(s));
      end
      repeat ($urandom_range(0, 3)) begin
        tick();
        sample();
        checks++;
        if ({ifA.out_valid, ifA.in_ready} !== 2'b10) begin
          failures++;
          $display("[TB] FAIL random_wait%0d: got v/r=%b expected 10", k, {ifA.out_valid, ifA.in_ready});
        end
      end
      ifA.out_ready = 1'b1;
      tick();
      ifA.out_ready = 1'b0;
      expCount = sat(expCount + int'(par(s)));
      sample();
      checks++;
      if ({ifA.out_valid, ifA.true_count} !== {1'b0, 8'(expCount)}) begin
        failures++;
        $display("[TB] FAIL random_count%0d: got valid=%b count=%0d expected valid=0 count=%0d",
                 k, ifA.out_valid, ifA.true_count, expCount);
      end
    end
  endtask

  // With in_valid held high the loader should take a new set every 4+SETTLE+1 cycles.
  task automatic test_back_to_back();
    localparam int PERIOD = 4 + SETTLE_A + 1;
    localparam int SETS   = 5;
    logic [3:0]  data[SETS*PERIOD];
    logic [15:0] obsOps[$];
    logic        obsRes[$];
    int          obsT[$];
    logic [15:0] exp;
    divSelA = 1'b1;
    ifA.out_ready = 1'b1;
    for (int t = 0; t < SETS*PERIOD; t++) data[t] = 4'($urandom);
    ifA.in_valid = 1'b1;
    for (int t = 0; t < SETS*PERIOD; t++) begin
      ifA.in_data = data[t];
      tick();
      sample();
      if (ifA.out_valid) begin
        obsOps.push_back({ifA.a, ifA.b, ifA.c, ifA.d});
        obsRes.push_back(ifA.out_result);
        obsT.push_back(t);
      end
    end
    ifA.in_valid = 1'b0;
    checks++;
    if (obsT.size() !== SETS) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d deliveries expected %0d", obsT.size(), SETS);
    end
    for (int k = 0; k < SETS && k < obsT.size(); k++) begin
      exp = {data[PERIOD*k], data[PERIOD*k+1], data[PERIOD*k+2], data[PERIOD*k+3]};
      expCount = sat(expCount + int'(par(exp)));
      checks++;
      if (obsOps[k] !== exp || obsRes[k] !== par(exp) || obsT[k] !== PERIOD*k + 3 + SETTLE_A) begin
        failures++;
        $display("[TB] FAIL b2b_set%0d: got ops=%h res=%b t=%0d expected ops=%h res=%b t=%0d",
                 k, obsOps[k], obsRes[k], obsT[k], exp, par(exp), PERIOD*k + 3 + SETTLE_A);
      end
    end
    checks++;
    if (ifA.true_count !== 8'(expCount)) begin
      failures++;
      $display("[TB] FAIL b2b_true_count: got %0d expected %0d", ifA.true_count, expCount);
    end
  endtask

  task automatic test_abort();
    int n;
    int deliveries;
    divSelA = 1'b0;
    divConstA = 1'b1;
    ifA.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expCount = 0;
    ifA.in_valid = 1'b1;
    ifA.in_data = 4'h7;
    tick();
    tick();
    ifA.in_valid = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if ({ifA.in_ready, ifA.out_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL abort_load_outputs: got %b expected 00", {ifA.in_ready, ifA.out_valid});
    end
    tick();
    rst = 1'b0;
    sample();
    checks++;
    if ({ifA.a, ifA.b, ifA.c, ifA.d, ifA.out_result, ifA.true_count} !== 25'd0) begin
      failures++;
      $display("[TB] FAIL abort_load_values: got %h expected 0",
               {ifA.a, ifA.b, ifA.c, ifA.d, ifA.out_result, ifA.true_count});
    end
    // Two more nibbles must not complete the abandoned set
    ifA.in_valid = 1'b1;
    ifA.in_data = 4'h5;
    tick();
    tick();
    ifA.in_valid = 1'b0;
    deliveries = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      sample();
      if (ifA.out_valid) deliveries++;
    end
    checks++;
    if (deliveries !== 0 || ifA.true_count !== 8'd0) begin
      failures++;
      $display("[TB] FAIL abort_no_delivery: got deliveries=%0d count=%0d expected 0 and 0",
               deliveries, ifA.true_count);
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifA.out_ready = 1'b0;
    sendSetA(16'hABCD);
    waitValidA(n);
    checks++;
    if (n !== SETTLE_A) begin
      failures++;
      $display("[TB] FAIL abort_hold_latency: got %0d expected %0d", n, SETTLE_A);
    end
    tick();
    rst = 1'b1;
    ifA.out_ready = 1'b1;
    #2;
    checks++;
    if ({ifA.in_ready, ifA.out_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL abort_hold_outputs: got %b expected 00", {ifA.in_ready, ifA.out_valid});
    end
    tick();
    rst = 1'b0;
    ifA.out_ready = 1'b0;
    sample();
    expCount = 0;
    checks++;
    if ({ifA.a, ifA.b, ifA.c, ifA.d, ifA.out_result, ifA.out_valid, ifA.true_count} !== 26'd0) begin
      failures++;
      $display("[TB] FAIL abort_hold_values: got %h expected 0",
               {ifA.a, ifA.b, ifA.c, ifA.d, ifA.out_result, ifA.out_valid, ifA.true_count});
    end
  endtask

  task automatic test_saturate();
    int deliveries;
    int cycles;
    divSelA = 1'b0;
    divConstA = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expCount = 0;
    ifA.out_ready = 1'b1;
    ifA.in_valid = 1'b1;
    deliveries = 0;
    cycles = 0;
    while (deliveries < 260 && cycles < 260 * 6 + 40) begin
      ifA.in_data = 4'($urandom);
      tick();
      sample();
      cycles++;
      if (ifA.out_valid) begin
        checks++;
        if (ifA.true_count !== 8'(sat(deliveries))) begin
          failures++;
          $display("[TB] FAIL sat_progress%0d: got %0d expected %0d",
                   deliveries, ifA.true_count, sat(deliveries));
        end
        deliveries++;
      end
    end
    ifA.in_valid = 1'b0;
    tick();
    sample();
    checks++;
    if (deliveries !== 260 || ifA.true_count !== 8'd255) begin
      failures++;
      $display("[TB] FAIL sat_final: got deliveries=%0d count=%0d expected 260 and 255",
               deliveries, ifA.true_count);
    end
    ifA.out_ready = 1'b0;
  endtask

  // Instance B: the captured bit must be the divider value during the 3rd cycle after
  // the 4th accept, checked with both starting phases of the toggling divider.
  task automatic test_settle3();
    int   expB;
    int   k;
    logic vals[8];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expB = 0;
    ifB.out_ready = 1'b0;
    for (int phase = 0; phase < 2; phase++) begin
      divB = phase[0];
      for (int i = 0; i < 4; i++) begin
        ifB.in_valid = 1'b1;
        ifB.in_data  = 4'(i + 1);
        tick();
        divB = ~divB;
      end
      ifB.in_valid = 1'b0;
      k = 0;
      do begin
        k++;
        vals[k] = divB;
        tick();
        sample();
        divB = ~divB;
      end while (!ifB.out_valid && k < 7);
      checks++;
      if (k !== SETTLE_B || ifB.out_result !== vals[SETTLE_B]) begin
        failures++;
        $display("[TB] FAIL settle3_phase%0d: got lat=%0d res=%b expected lat=%0d res=%b",
                 phase, k, ifB.out_result, SETTLE_B, vals[SETTLE_B]);
      end
      expB += int'(vals[SETTLE_B]);
      tick();
      ifB.out_ready = 1'b1;
      tick();
      ifB.out_ready = 1'b0;
      sample();
      checks++;
      if ({ifB.out_valid, ifB.true_count, ifB.a, ifB.b, ifB.c, ifB.d} !== {1'b0, 8'(expB), 16'h1234}) begin
        failures++;
        $display("[TB] FAIL settle3_deliver%0d: got v=%b count=%0d ops=%h expected v=0 count=%0d ops=1234",
                 phase, ifB.out_valid, ifB.true_count, {ifB.a, ifB.b, ifB.c, ifB.d}, expB);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    divSelA = 1'b0;
    divConstA = 1'b0;
    divB = 1'b0;
    ifA.in_valid = 1'b0;
    ifA.in_data = 4'h0;
    ifA.flush = 1'b0;
    ifA.out_ready = 1'b0;
    ifB.in_valid = 1'b0;
    ifB.in_data = 4'h0;
    ifB.flush = 1'b0;
    ifB.out_ready = 1'b0;

    test_reset();
    test_basic();
    test_flush();
    test_hold();
    test_random();
    test_back_to_back();
    test_abort();
    test_saturate();
    test_settle3();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_operand_loader.md
DIV_OPERAND_LOADER -- requirements
Module: div_operand_loader

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving the number of cycles operands are held before div_result is sampled (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the true-result counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, upstream nibble present.
REQ-007 SHALL have port in_data, input, 4, operand nibble.
REQ-008 SHALL have port in_ready, output, 1, loader accepts a nibble this cycle.
REQ-009 SHALL have port flush, input, 1, discards a partially loaded operand set.
REQ-010 SHALL have ports a, b, c, d, output, 4 each, registered operands driven to the downstream div block.
REQ-011 SHALL have port div_result, input, 1, combinational result returned by div.
REQ-012 SHALL have ports out_valid (output, 1), out_result (output, 1) and out_ready (input, 1), the result handshake.
REQ-013 SHALL have port true_count, output, CNT_W, the number of delivered results equal to 1.

Function
REQ-014 SHALL implement three states: LOAD, SETTLE and HOLD.
REQ-015 LOAD: in_ready = !flush; a nibble is accepted when in_valid && in_ready.
- Accepted nibbles are written in order to a, b, c, d, selected by a 2-bit index idx.
REQ-016 On accepting the 4th nibble (idx = 3), the state SHALL go to SETTLE, idx SHALL reset to 0, and the settle counter SHALL load SETTLE_CYCLES-1.
REQ-017 flush in LOAD SHALL reset idx to 0 and leave a..d unchanged.
- A nibble presented in the same cycle as flush SHALL NOT be accepted.
REQ-018 flush SHALL be ignored in SETTLE and HOLD.
REQ-019 SETTLE: in_ready = 0 and the settle counter decrements each cycle.
- When the counter is 0, div_result SHALL be captured into out_result and the state SHALL go to HOLD.
- out_valid SHALL rise exactly SETTLE_CYCLES cycles after the edge that accepted the 4th nibble.
REQ-020 HOLD: out_valid = 1, in_ready = 0, and out_result and a..d SHALL be stable.
- When out_ready = 1, the result SHALL be delivered: out_valid falls on the next edge and the state goes to LOAD.
REQ-021 a..d SHALL change only on nibble acceptance or reset; they SHALL hold their values through SETTLE, HOLD and subsequent LOAD until overwritten.
REQ-022 On each delivery with out_result = 1, true_count SHALL increment.
- true_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 Back-to-back operation: the first nibble of the next set MAY be accepted in the cycle immediately after delivery.
- Minimum period = 4 + SETTLE_CYCLES + 1 cycles.
REQ-024 out_valid and in_ready SHALL never both be 1 in the same cycle.

Reset
REQ-025 While rst = 1, the next state SHALL be LOAD with idx = 0 and the settle counter at 0.
- a, b, c, d, out_result and true_count SHALL reset to 0.
REQ-026 in_ready and out_valid SHALL be 0 while rst is high.
- in_ready SHALL rise in the first cycle after rst deasserts.
REQ-027 rst asserted in any state, including mid-load, SETTLE or HOLD, SHALL abandon the operation with no partial result delivered and no counter update.

Structure
REQ-028 A shared package SHALL hold the state enum (LOAD, SETTLE, HOLD), the 4-bit nibble type and the default SETTLE_CYCLES constant.
REQ-029 The block SHALL be a single module with no sub-modules.
- The div instance is wired externally at the next level up.

Verification
REQ-030 Load 3,3,0,0 with div_result tied to 1 and out_ready = 1 -> a=3, b=3, c=0, d=0; out_valid high for one cycle, 5 cycles after the first accept; out_result = 1; true_count = 1.
REQ-031 Load 1, 2, flush, then 9,9,9,9 -> a=b=c=d=9; the flush-cycle nibble is not accepted; exactly one result is delivered.
REQ-032 Hold out_ready = 0 for 10 cycles in HOLD -> out_valid, out_result and a..d are stable, in_ready = 0, and in_valid pulses are ignored.
REQ-033 With SETTLE_CYCLES = 3, toggle div_result each cycle -> the captured value equals div_result at the 3rd cycle after the 4th accept.
REQ-034 Assert rst after the 2nd nibble, and separately in HOLD -> all outputs are 0, no delivery occurs, and true_count is unchanged at 0.
REQ-035 Run 260 deliveries with result 1 at CNT_W = 8 -> true_count saturates at 255.
